// File: rtl/cpu64_l1_pkg.sv
// Shared L1 data-cache geometry and refill state encoding.
// A 64-bit physical address splits as [63:12] tag, [11:6] set, [5:0] byte offset.
package cpu64_l1_pkg;

  localparam int NUM_SETS   = 64;
  localparam int NUM_WAYS   = 8;
  localparam int LINE_BYTES = 64;
  localparam int TAG_W      = 52;

  // Address field positions
  localparam int OFFSET_W  = 6;
  localparam int INDEX_LSB = 6;
  localparam int INDEX_W   = 6;
  localparam int TAG_LSB   = 12;

  // Way index and beat counter widths
  localparam int WAY_W  = 3;
  localparam int BEAT_W = 3;

  // Refill controller states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VICTIM,
    ST_WB_REQ,
    ST_WB_DATA,
    ST_RD_REQ,
    ST_RD_DATA,
    ST_COMMIT
  } refill_state_e;

endpackage

// File: rtl/cpu64_l1_refill_fsm.sv
// L1 miss refill controller.
// Accepts one miss at a time. It writes back the PLRU victim line when that line
// is valid and dirty, then fetches the missing line into the victim way. After
// that it writes the new tag and touches the PLRU for that way. It sits next to
// cpu64_l1_plru: set_o feeds the PLRU set_i, victim_i comes from its victim_o,
// and plru_access_o/plru_way_o drive its access_i/used_way_i.
module cpu64_l1_refill_fsm
  import cpu64_l1_pkg::*;
#(
  parameter int LINE_BEATS = 8,
  parameter int ADDR_W     = 64
) (
  input  logic                clk_i,
  input  logic                rst_ni,

  input  logic                miss_valid_i,
  output logic                miss_ready_o,
  input  logic [ADDR_W-1:0]   miss_addr_i,

  output logic [INDEX_W-1:0]  set_o,
  input  logic [NUM_WAYS-1:0] valid_i,
  input  logic [WAY_W-1:0]    victim_i,
  input  logic                victim_dirty_i,
  input  logic [TAG_W-1:0]    victim_tag_i,

  output logic                mem_req_valid_o,
  input  logic                mem_req_ready_i,
  output logic                mem_req_we_o,
  output logic [ADDR_W-1:0]   mem_req_addr_o,

  output logic                mem_wvalid_o,
  input  logic                mem_wready_i,
  output logic [63:0]         mem_wdata_o,

  input  logic                mem_rvalid_i,
  input  logic [63:0]         mem_rdata_i,

  output logic [WAY_W-1:0]    arr_way_o,
  output logic [BEAT_W-1:0]   arr_beat_o,
  output logic                arr_we_o,
  output logic [63:0]         arr_wdata_o,
  input  logic [63:0]         arr_rdata_i,

  output logic                tag_we_o,
  output logic [TAG_W-1:0]    tag_wdata_o,

  output logic                plru_access_o,
  output logic [WAY_W-1:0]    plru_way_o,

  output logic                done_o
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_BYTES - 1);

  refill_state_e       state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [WAY_W-1:0]    way_q, way_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [TAG_W-1:0]    vtag_q, vtag_d;

  logic [TAG_W-1:0]    miss_tag;
  logic [ADDR_W-1:0]   rd_line_addr;
  logic [ADDR_W-1:0]   wb_line_addr;

  // The captured miss address provides the set for the whole refill, the tag
  // to install, and both line-aligned memory addresses.
  assign set_o        = addr_q[INDEX_LSB +: INDEX_W];
  assign miss_tag     = TAG_W'(addr_q >> TAG_LSB);
  assign rd_line_addr = addr_q & LINE_MASK;
  assign wb_line_addr = ADDR_W'({vtag_q, set_o, {OFFSET_W{1'b0}}});

  assign arr_way_o   = way_q;
  assign arr_beat_o  = beat_q;
  assign tag_wdata_o = miss_tag;
  assign plru_way_o  = way_q;

  // State, beat counter, chosen way and captured addresses; reset abandons any refill
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      way_q   <= '0;
      addr_q  <= '0;
      vtag_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      way_q   <= way_d;
      addr_q  <= addr_d;
      vtag_q  <= vtag_d;
    end
  end

  // Next-state logic: the victim is sampled once, and each data phase counts its own beats from zero
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    way_d   = way_q;
    addr_d  = addr_q;
    vtag_d  = vtag_q;
    unique case (state_q)
      ST_IDLE: begin
        if (miss_valid_i) begin
          addr_d  = miss_addr_i;
          state_d = ST_VICTIM;
        end
      end
      ST_VICTIM: begin
        way_d  = victim_i;
        vtag_d = victim_tag_i;
        beat_d = '0;
        if (valid_i[victim_i] && victim_dirty_i) begin
          state_d = ST_WB_REQ;
        end else begin
          state_d = ST_RD_REQ;
        end
      end
      ST_WB_REQ: begin
        if (mem_req_ready_i) begin
          beat_d  = '0;
          state_d = ST_WB_DATA;
        end
      end
      ST_WB_DATA: begin
        if (mem_wready_i) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = ST_RD_REQ;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      ST_RD_REQ: begin
        if (mem_req_ready_i) begin
          beat_d  = '0;
          state_d = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (mem_rvalid_i) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = ST_COMMIT;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the registered state; only the data-phase handshakes pass through combinationally
  always_comb begin
    miss_ready_o    = 1'b0;
    mem_req_valid_o = 1'b0;
    mem_req_we_o    = 1'b0;
    mem_req_addr_o  = '0;
    mem_wvalid_o    = 1'b0;
    mem_wdata_o     = '0;
    arr_we_o        = 1'b0;
    arr_wdata_o     = '0;
    tag_we_o        = 1'b0;
    plru_access_o   = 1'b0;
    done_o          = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        miss_ready_o = 1'b1;
      end
      ST_WB_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_req_we_o    = 1'b1;
        mem_req_addr_o  = wb_line_addr;
      end
      ST_WB_DATA: begin
        mem_wvalid_o = 1'b1;
        mem_wdata_o  = arr_rdata_i;
      end
      ST_RD_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_req_addr_o  = rd_line_addr;
      end
      ST_RD_DATA: begin
        arr_we_o    = mem_rvalid_i;
        arr_wdata_o = mem_rdata_i;
      end
      ST_COMMIT: begin
        tag_we_o      = 1'b1;
        plru_access_o = 1'b1;
        done_o        = 1'b1;
      end
      default: begin
        miss_ready_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu64_l1_refill_fsm.sv
// Self-checking bench for the L1 refill controller.
// It uses a table of directed misses plus randomized misses, which are checked
// against a transaction-level model of the refill. A hand-written sequence
// asserts reset in the middle of a refill.
module tb_cpu64_l1_refill_fsm;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        miss_valid_i;
  logic        miss_ready_o;
  logic [63:0] miss_addr_i;
  logic [5:0]  set_o;
  logic [7:0]  valid_i;
  logic [2:0]  victim_i;
  logic        victim_dirty_i;
  logic [51:0] victim_tag_i;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic        mem_req_we_o;
  logic [63:0] mem_req_addr_o;
  logic        mem_wvalid_o;
  logic        mem_wready_i;
  logic [63:0] mem_wdata_o;
  logic        mem_rvalid_i;
  logic [63:0] mem_rdata_i;
  logic [2:0]  arr_way_o;
  logic [2:0]  arr_beat_o;
  logic        arr_we_o;
  logic [63:0] arr_wdata_o;
  logic [63:0] arr_rdata_i;
  logic        tag_we_o;
  logic [51:0] tag_wdata_o;
  logic        plru_access_o;
  logic [2:0]  plru_way_o;
  logic        done_o;

  int total = 0;
  int bad   = 0;
  int cur_case = -1;

  typedef struct {
    logic [63:0] addr;
    logic [2:0]  victim;
    logic [7:0]  valid;
    logic        dirty;
    logic [51:0] vtag;
    int          req_stall;
    int          wmode;
    int          rgap;
    bit          hold_miss;
    bit          spurious;
    bit          exp_wb;
    logic [63:0] exp_wb_addr;
    logic [63:0] exp_rd_addr;
    logic [51:0] exp_tag;
    logic [2:0]  exp_way;
  } refill_case_t;

  refill_case_t cases[$];

  cpu64_l1_refill_fsm #(.LINE_BEATS(8), .ADDR_W(64)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .miss_valid_i(miss_valid_i), .miss_ready_o(miss_ready_o), .miss_addr_i(miss_addr_i),
    .set_o(set_o), .valid_i(valid_i), .victim_i(victim_i),
    .victim_dirty_i(victim_dirty_i), .victim_tag_i(victim_tag_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_we_o(mem_req_we_o), .mem_req_addr_o(mem_req_addr_o),
    .mem_wvalid_o(mem_wvalid_o), .mem_wready_i(mem_wready_i), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .arr_way_o(arr_way_o), .arr_beat_o(arr_beat_o), .arr_we_o(arr_we_o),
    .arr_wdata_o(arr_wdata_o), .arr_rdata_i(arr_rdata_i),
    .tag_we_o(tag_we_o), .tag_wdata_o(tag_wdata_o),
    .plru_access_o(plru_access_o), .plru_way_o(plru_way_o),
    .done_o(done_o)
  );

  // Free-running clock
  always #5 clk_i = ~clk_i;

  // Data-array contents are a fixed pattern of set, way and beat
  function automatic logic [63:0] arrData(input logic [5:0] s, input logic [2:0] w, input logic [2:0] b);
    return 64'hC0DE_0000_0000_005A | (64'(s) << 24) | (64'(w) << 16) | (64'(b) << 8);
  endfunction

  assign arr_rdata_i = arrData(set_o, arr_way_o, arr_beat_o);

  // Transaction-level model: what a refill of this miss must produce
  function automatic refill_case_t model(input refill_case_t c);
    refill_case_t r = c;
    r.exp_wb      = (((c.valid >> c.victim) & 8'd1) != 8'd0) && c.dirty;
    r.exp_rd_addr = c.addr - (c.addr % 64);
    r.exp_wb_addr = (64'(c.vtag) << 12) + ((c.addr / 64) % 64) * 64;
    r.exp_tag     = 52'(c.addr / 4096);
    r.exp_way     = c.victim;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s (case %0d): got %h expected %h", name, cur_case, actual, expected);
    end
  endtask

  task automatic idleInputs();
    miss_valid_i    = 1'b0;
    miss_addr_i     = '0;
    mem_req_ready_i = 1'b0;
    mem_wready_i    = 1'b0;
    mem_rvalid_i    = 1'b0;
    mem_rdata_i     = '0;
  endtask

  // Runs one complete miss against a responding memory and compares the observed transactions
  task automatic applyStimulus(input refill_case_t c);
    logic [63:0] rd_beats [8];
    logic [63:0] req_addr [4];
    logic        req_we   [4];
    logic [63:0] prev_addr;
    logic        prev_we;
    logic [5:0]  exp_set;
    int req_count, w_count, a_count, tag_count, plru_count, done_count;
    int stall_left, r_sent, r_timer;
    bit req_pending, rd_accepted, done_seen, wtog;
    exp_set = c.addr[11:6];
    req_count = 0; w_count = 0; a_count = 0; tag_count = 0; plru_count = 0; done_count = 0;
    stall_left = 0; r_sent = 0; r_timer = 0;
    req_pending = 0; rd_accepted = 0; done_seen = 0; wtog = 0;
    prev_addr = '0; prev_we = 1'b0;
    for (int i = 0; i < 8; i++) rd_beats[i] = {$urandom, $urandom};
    for (int i = 0; i < 4; i++) begin req_addr[i] = '0; req_we[i] = 1'b0; end

    @(negedge clk_i);
    valid_i        = c.valid;
    victim_i       = c.victim;
    victim_dirty_i = c.dirty;
    victim_tag_i   = c.vtag;
    miss_valid_i   = 1'b1;
    miss_addr_i    = c.addr;
    mem_req_ready_i = 1'b0;
    mem_wready_i    = 1'b0;
    mem_rvalid_i    = c.spurious;
    mem_rdata_i     = 64'hBAD0_BAD0_BAD0_BAD0;
    #1;
    checkOutput("idle_ready", miss_ready_o, 1);
    checkOutput("idle_no_arr_we", arr_we_o, 0);

    for (int cyc = 0; cyc < 300 && !done_seen; cyc++) begin
      @(negedge clk_i);
      if (c.hold_miss) miss_addr_i = {$urandom, $urandom};
      else begin
        miss_valid_i = 1'b0;
        miss_addr_i  = '0;
      end
      if (mem_req_valid_o) begin
        if (!req_pending) stall_left = c.req_stall;
        mem_req_ready_i = (stall_left == 0);
        if (stall_left > 0) stall_left--;
      end else begin
        mem_req_ready_i = 1'b0;
      end
      wtog = ~wtog;
      case (c.wmode)
        0:       mem_wready_i = 1'b1;
        1:       mem_wready_i = wtog;
        default: mem_wready_i = 1'($urandom % 2);
      endcase
      mem_rvalid_i = 1'b0;
      if (!rd_accepted && c.spurious) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 64'hBAD0_BAD0_BAD0_BAD0;
      end else if (rd_accepted && r_sent < 8) begin
        r_timer++;
        if (r_timer >= c.rgap) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = rd_beats[r_sent];
          r_sent++;
          r_timer = 0;
        end
      end
      #1;
      checkOutput("miss_ready_busy", miss_ready_o, 0);
      checkOutput("set_held", set_o, exp_set);
      if (req_pending) begin
        checkOutput("req_held", mem_req_valid_o, 1);
        checkOutput("req_addr_stable", mem_req_addr_o, prev_addr);
        checkOutput("req_we_stable", mem_req_we_o, prev_we);
      end
      if (mem_req_valid_o) begin
        if (mem_req_ready_i) begin
          if (req_count < 4) begin
            req_addr[req_count] = mem_req_addr_o;
            req_we[req_count]   = mem_req_we_o;
          end
          req_count++;
          req_pending = 0;
          if (!mem_req_we_o) rd_accepted = 1;
        end else begin
          req_pending = 1;
          prev_addr   = mem_req_addr_o;
          prev_we     = mem_req_we_o;
        end
      end else begin
        req_pending = 0;
      end
      if (mem_wvalid_o) begin
        checkOutput("wb_data", mem_wdata_o, arrData(exp_set, c.exp_way, 3'(w_count)));
        if (mem_wready_i) w_count++;
      end
      if (arr_we_o) begin
        if (a_count < 8) begin
          checkOutput("arr_way", arr_way_o, c.exp_way);
          checkOutput("arr_beat", arr_beat_o, a_count);
          checkOutput("arr_wdata", arr_wdata_o, rd_beats[a_count]);
        end
        a_count++;
      end
      if (tag_we_o) begin
        tag_count++;
        checkOutput("tag_wdata", tag_wdata_o, c.exp_tag);
      end
      if (plru_access_o) begin
        plru_count++;
        checkOutput("plru_way", plru_way_o, c.exp_way);
      end
      if (done_o) begin
        done_count++;
        done_seen = 1;
      end
    end

    checkOutput("refill_completed", done_seen, 1);
    checkOutput("req_count", req_count, c.exp_wb ? 2 : 1);
    if (c.exp_wb) begin
      checkOutput("wb_req_we", req_we[0], 1);
      checkOutput("wb_req_addr", req_addr[0], c.exp_wb_addr);
      checkOutput("rd_req_we", req_we[1], 0);
      checkOutput("rd_req_addr", req_addr[1], c.exp_rd_addr);
    end else begin
      checkOutput("rd_req_we", req_we[0], 0);
      checkOutput("rd_req_addr", req_addr[0], c.exp_rd_addr);
    end
    checkOutput("wb_beat_count", w_count, c.exp_wb ? 8 : 0);
    checkOutput("arr_we_count", a_count, 8);
    checkOutput("tag_we_count", tag_count, 1);
    checkOutput("plru_count", plru_count, 1);
    checkOutput("done_count", done_count, 1);

    @(negedge clk_i);
    idleInputs();
    #1;
    checkOutput("ready_after_done", miss_ready_o, 1);
    checkOutput("done_single_pulse", done_o, 0);
  endtask

  // Starts a clean refill and pulls reset low while beat 4 is on the bus
  task automatic applyResetMidRefill();
    bit got_req;
    got_req = 0;
    @(negedge clk_i);
    valid_i = 8'h00; victim_i = 3'd6; victim_dirty_i = 1'b0; victim_tag_i = 52'h0;
    miss_valid_i = 1'b1; miss_addr_i = 64'h0000_0000_0042_1080;
    mem_req_ready_i = 1'b1;
    for (int k = 0; k < 10 && !got_req; k++) begin
      @(negedge clk_i);
      miss_valid_i = 1'b0;
      #1;
      if (mem_req_valid_o) got_req = 1;
    end
    checkOutput("rst_rd_req_seen", got_req, 1);
    checkOutput("rst_rd_req_addr", mem_req_addr_o, 64'h0000_0000_0042_1080);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk_i);
      mem_req_ready_i = 1'b0;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 64'(b);
    end
    @(negedge clk_i);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 64'h4;
    #1;
    checkOutput("rst_beat4_we", arr_we_o, 1);
    checkOutput("rst_beat4_idx", arr_beat_o, 4);
    #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("rst_async_miss_ready", miss_ready_o, 1);
    checkOutput("rst_async_arr_we", arr_we_o, 0);
    checkOutput("rst_async_set", set_o, 0);
    checkOutput("rst_async_beat", arr_beat_o, 0);
    checkOutput("rst_async_way", arr_way_o, 0);
    checkOutput("rst_async_req_valid", mem_req_valid_o, 0);
    checkOutput("rst_async_tag_we", tag_we_o, 0);
    checkOutput("rst_async_done", done_o, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      mem_rvalid_i = 1'b0;
      #1;
      checkOutput("rst_hold_tag_we", tag_we_o, 0);
      checkOutput("rst_hold_plru", plru_access_o, 0);
      checkOutput("rst_hold_done", done_o, 0);
    end
    @(negedge clk_i);
    idleInputs();
    rst_ni = 1'b1;
  endtask

  // Main sequence: reset, directed table, mid-refill reset, random misses
  initial begin
    refill_case_t c;
    rst_ni = 1'b0;
    idleInputs();
    valid_i = '0; victim_i = '0; victim_dirty_i = 1'b0; victim_tag_i = '0;

    // addr, victim, valid, dirty, vtag, stall, wmode, rgap, hold, spur, exp_wb, exp_wb_addr, exp_rd_addr, exp_tag, exp_way
    cases.push_back('{64'h0000_0000_1000_0040, 3'd5, 8'hDF, 1'b1, 52'h123, 0, 0, 1, 0, 0,
                      1'b0, 64'h0, 64'h0000_0000_1000_0040, 52'h10000, 3'd5});
    cases.push_back('{64'h0000_0000_0077_70C0, 3'd2, 8'hFF, 1'b1, 52'hABC, 0, 0, 1, 0, 0,
                      1'b1, 64'h0000_0000_00AB_C0C0, 64'h0000_0000_0077_70C0, 52'h777, 3'd2});
    cases.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 3'd7, 8'h80, 1'b1, 52'h1, 5, 1, 1, 0, 0,
                      1'b1, 64'h0000_0000_0000_1FC0, 64'hFFFF_FFFF_FFFF_FFC0, 52'hF_FFFF_FFFF_FFFF, 3'd7});
    cases.push_back('{64'h0000_0000_0000_0000, 3'd0, 8'h01, 1'b0, 52'h9, 0, 0, 3, 0, 1,
                      1'b0, 64'h0, 64'h0, 52'h0, 3'd0});
    cases.push_back('{64'hDEAD_BEEF_CAFE_1234, 3'd3, 8'h00, 1'b1, 52'h42, 2, 0, 2, 1, 0,
                      1'b0, 64'h0, 64'hDEAD_BEEF_CAFE_1200, 52'hD_EADB_EEFC_AFE1, 3'd3});
    cases.push_back('{64'h0123_4567_89AB_CDEF, 3'd4, 8'h10, 1'b1, 52'h5_5555_5555_5555, 1, 2, 1, 0, 0,
                      1'b1, 64'h5555_5555_5555_5DC0, 64'h0123_4567_89AB_CDC0, 52'h0_1234_5678_9ABC, 3'd4});

    repeat (2) @(negedge clk_i);
    #1;
    checkOutput("reset_miss_ready", miss_ready_o, 1);
    checkOutput("reset_set", set_o, 0);
    checkOutput("reset_req_valid", mem_req_valid_o, 0);
    checkOutput("reset_wvalid", mem_wvalid_o, 0);
    checkOutput("reset_arr_we", arr_we_o, 0);
    checkOutput("reset_tag_we", tag_we_o, 0);
    checkOutput("reset_done", done_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < cases.size(); i++) begin
      cur_case = i;
      applyStimulus(cases[i]);
    end

    cur_case = 100;
    applyResetMidRefill();
    cur_case = 101;
    applyStimulus(cases[1]);

    for (int i = 0; i < 24; i++) begin
      cur_case = 200 + i;
      c.addr      = {$urandom, $urandom};
      c.victim    = 3'($urandom_range(0, 7));
      c.valid     = 8'($urandom);
      c.dirty     = 1'($urandom % 2);
      c.vtag      = {20'($urandom), 32'($urandom)};
      c.req_stall = $urandom_range(0, 4);
      c.wmode     = $urandom_range(0, 2);
      c.rgap      = $urandom_range(1, 3);
      c.hold_miss = 1'($urandom % 2);
      c.spurious  = 1'($urandom % 2);
      applyStimulus(model(c));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a hung handshake
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/cpu64_l1_refill_fsm.md
CPU64_L1_REFILL_FSM -- requirements
Module: cpu64_l1_refill_fsm

Interface
REQ-001 SHALL have parameters LINE_BEATS, default 8, 64-bit beats per 64-byte line; ADDR_W, default 64, physical address width.
REQ-002 clk_i  in  1  clock, rising edge.
REQ-003 rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 miss_valid_i / miss_ready_o  in/out  1/1  miss request handshake from L1 lookup.
REQ-005 miss_addr_i  in  ADDR_W  missing address; [11:6]=set, [63:12]=tag.
REQ-006 set_o  out  6  set index presented to the PLRU, tag and data arrays; held for the whole refill.
REQ-007 valid_i / victim_i  in  8/3  valid mask of set_o (also fed to PLRU) / PLRU victim way.
REQ-008 victim_dirty_i / victim_tag_i  in  1/52  dirty bit and tag of the way victim_i in set set_o.
REQ-009 mem_req_valid_o / mem_req_ready_i / mem_req_we_o / mem_req_addr_o  out/in/out/out  1/1/1/ADDR_W  line request; the address is line-aligned.
REQ-010 mem_wvalid_o / mem_wready_i / mem_wdata_o  out/in/out  1/1/64  writeback beats.
REQ-011 mem_rvalid_i / mem_rdata_i  in  1/64  refill beats; no backpressure.
REQ-012 arr_way_o / arr_beat_o / arr_we_o / arr_wdata_o / arr_rdata_i  out/out/out/out/in  3/3/1/64/64  data-array port; the read is combinational on {set_o, arr_way_o, arr_beat_o}.
REQ-013 tag_we_o / tag_wdata_o  out/out  1/52  tag write; it sets valid=1 and dirty=0 for the way arr_way_o.
REQ-014 plru_access_o / plru_way_o  out/out  1/3  PLRU update pulse.
REQ-015 done_o  out  1  one-cycle pulse when the refill is complete.

Function
REQ-016 SHALL implement states IDLE, VICTIM, WB_REQ, WB_DATA, RD_REQ, RD_DATA, COMMIT.
REQ-017 IDLE: miss_ready_o=1; on miss_valid_i it captures the address and goes to VICTIM; miss_ready_o=0 in every other state.
REQ-018 VICTIM (1 cycle): latches victim_i into the way register. If valid_i[victim_i] and victim_dirty_i are both set, it goes to WB_REQ; otherwise it goes to RD_REQ.
REQ-019 WB_REQ: mem_req_valid_o=1, we=1, addr={victim_tag_i latched, set, 6'b0}; it goes to WB_DATA on ready.
REQ-020 WB_DATA: mem_wvalid_o=1, mem_wdata_o=arr_rdata_i at beat counter; the counter advances only on mem_wready_i; after beat LINE_BEATS-1 is accepted it goes to RD_REQ.
REQ-021 RD_REQ: mem_req_valid_o=1, we=0, addr={miss tag, set, 6'b0}; it goes to RD_DATA on ready.
REQ-022 RD_DATA: each mem_rvalid_i asserts arr_we_o with arr_wdata_o=mem_rdata_i and arr_beat_o=counter; after beat LINE_BEATS-1 it goes to COMMIT.
REQ-023 COMMIT (1 cycle): tag_we_o=1, plru_access_o=1, plru_way_o=way, done_o=1; then it returns to IDLE.
REQ-024 The request valid SHALL hold with a stable address until ready; it SHALL NOT drop before ready.
REQ-025 Beat counter: 3 bits, wraps to 0 on transition out of a data state; it is zeroed on entry to each data state.
REQ-026 mem_rvalid_i outside RD_DATA SHALL be ignored; mem_wready_i outside WB_DATA SHALL be ignored.
REQ-027 All strobes other than the ones listed per state SHALL be 0; outputs are registered-state decodes with no combinational path from miss_valid_i to mem_* outputs.

Reset
REQ-028 Reset SHALL force IDLE, counter=0, way=0 and captured address=0; all valid/we/pulse outputs are 0, miss_ready_o=1, set_o=0.
REQ-029 Reset mid-refill SHALL abandon the transaction with no tag_we_o or plru_access_o pulse; the partial line is left invalid-tag.

Structure
REQ-030 The shared package cpu64_l1_pkg SHALL hold NUM_SETS=64, NUM_WAYS=8, LINE_BYTES=64, TAG_W=52, the index/offset bit positions and the state enum.
REQ-031 The block is a single module with no submodules; it is instantiated alongside cpu64_l1_plru, driving its set_i/access_i/used_way_i and consuming victim_o.

Verification
REQ-032 Clean miss, addr 0x1000_0040, victim_i=5 with valid_i[5]=0 -> read request at 0x1000_0040; 8 arr_we_o pulses on way 5, beats 0..7; COMMIT with plru_way_o=5 and a single done_o pulse.
REQ-033 Dirty victim, victim_i=2, victim_tag=0xABC, set 3 -> write request to addr {0xABC,3,0}; 8 beats of arr_rdata_i; then read request; tag_wdata_o equals the miss tag.
REQ-034 Backpressure: mem_req_ready_i low for 5 cycles and mem_wready_i toggling -> address and wdata stable while stalled; exactly 8 beats accepted.
REQ-035 Gapped refill, mem_rvalid_i every third cycle -> beats land in order 0..7; a spurious rvalid before RD_DATA is ignored.
REQ-036 rst_ni low during beat 4 of RD_DATA -> outputs reach reset values asynchronously; no tag_we_o or done_o; a new miss is accepted after release.
REQ-037 A miss_valid_i held high during a refill -> no second capture until the cycle after done_o.
